// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the serial adder
// Purpose: FSM state enum, slice width and default operand width used by
//          serial_add_seq and its testbench.
// Ports:   none (package).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W       = 2;
  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/add2_slice.sv
// rtl/add2_slice.sv - combinational 2-bit ripple adder slice
// Purpose: adds one 2-bit slice of two operands plus a carry-in.
// Ports:
//   a, b  : 2-bit slice operands
//   cin   : carry into bit 0
//   s     : 2-bit slice sum
//   cout  : carry out of bit 1
//   c1    : carry into bit 1 (needed for signed overflow on the top slice)
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout,
  output logic       c1
);

  logic [1:0] lo;
  logic [1:0] hi;

  assign lo    = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, cin};
  assign hi    = {1'b0, a[1]} + {1'b0, b[1]} + {1'b0, lo[1]};
  assign s     = {hi[0], lo[0]};
  assign c1    = lo[1];
  assign cout  = hi[1];

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - sequential adder processing two bits per cycle
// Purpose: accepts an operand pair, adds it one 2-bit slice per cycle over
//          WIDTH/2 cycles, then presents sum and carry-out until taken.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready   : result handshake (out_sum, out_cout)
//   busy                  : high whenever the FSM is not IDLE
//   out_ovf               : signed overflow, only when SERIAL_ADD_SEQ_OVF_EN
//                           is defined
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef SERIAL_ADD_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_work_q;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   bit_pos;
  logic             last_slice;

  logic [1:0]       sl_s;
  logic             sl_cout;
  logic             sl_c1;

  assign bit_pos    = {idx_q, 1'b0};
  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  add2_slice u_slice (
    .a    (a_q[bit_pos +: SLICE_W]),
    .b    (b_q[bit_pos +: SLICE_W]),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_cout),
    .c1   (sl_c1)
  );

  // Working sum with the current slice merged in; also the final result on
  // the last RUN cycle.
  always_comb begin
    sum_next = sum_work_q;
    sum_next[bit_pos +: SLICE_W] = sl_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath. The published result lives in separate registers so it stays
  // at the previous value while the next operation is being computed.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_work_q <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_work_q <= sum_next;
          carry_q    <= sl_cout;
          if (last_slice) begin
            out_sum_q  <= sum_next;
            out_cout_q <= sl_cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = out_sum_q;
  assign out_cout = out_cout_q;

`ifdef SERIAL_ADD_SEQ_OVF_EN
  logic out_ovf_q;

  // On the top slice, sl_c1 is the carry into bit WIDTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf_q <= 1'b0;
    end else if (state_q == RUN && last_slice) begin
      out_ovf_q <= sl_c1 ^ sl_cout;
    end
  end

  assign out_ovf = out_ovf_q;
`else
  logic unused_c1;
  assign unused_c1 = sl_c1;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - randomized self-checking bench for serial_add_seq
module tb_serial_add_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef SERIAL_ADD_SEQ_OVF_EN
  logic         out_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] prev_sum;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef SERIAL_ADD_SEQ_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction against an arithmetic reference.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, input bit inject);
    logic [W:0] full;
    logic       ovf;
    int         k;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);

    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", in_ready, 1);
    tick();
    check("busy_run", busy, 1);
    check("sum_retained_in_run", out_sum, prev_sum);
    if (inject) begin
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end

    k = 0;
    while (!out_valid && k < 40) begin
      if (in_ready !== 1'b0) check("in_ready_run", in_ready, 0);
      tick();
      k++;
    end
    in_valid = 1'b0;
    check("latency", k, W / 2);
    check("out_sum", out_sum, full[W-1:0]);
    check("out_cout", out_cout, full[W]);
`ifdef SERIAL_ADD_SEQ_OVF_EN
    check("out_ovf", out_ovf, ovf);
`else
    if (ovf === 1'bx) check("ovf_model", ovf, 0);
`endif

    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, full[W-1:0]);
      check("hold_cout", out_cout, full[W]);
      check("hold_in_ready", in_ready, 0);
    end

    // A fresh pair offered in the handshake cycle must not be taken.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = W'($urandom); in_b = W'($urandom);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check("post_sum_kept", out_sum, full[W-1:0]);
    prev_sum = full[W-1:0];
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    prev_sum = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);

    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 5, 1'b0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 0, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 2, 1'b0);

    // Abort on the third RUN cycle.
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", out_sum, 0);
    check("abort_cout", out_cout, 0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", seen, 0);
    end
    prev_sum = '0;

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
